qadd_rr_share: RTL

Shares one saturating fixed-point adder (`qadd`) between `NREQ` requesters. Operands are granted round-robin and carried through a two-stage pipeline with valid/ready backpressure. Results return tagged with the requester index and a saturation flag. The block sits between parallel accumulation lanes and a single adder resource.

---
 rtl/qadd_pkg.sv | 15 +
 rtl/qadd_rr_share_if.sv | 26 ++
 rtl/qadd.sv | 22 ++
 rtl/qadd_rr_share_rr_arb.sv | 27 ++
 rtl/qadd_rr_share.sv | 87 ++++++++
 5 files changed

// File: rtl/qadd_pkg.sv
// Shared defaults and saturation constants for the fixed-point adder.
package qadd_pkg;
  localparam int QADD_N = 20;
  localparam int QADD_Q = 11;

  typedef logic signed [QADD_N-1:0] qword_t;

  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/qadd_rr_share_if.sv
// Requester-side operand bus and single result port of the shared adder.
interface qadd_rr_share_if #(
  parameter int N    = 20,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [N-1:0]           rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_sat;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_sat
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_sat
  );
endinterface

// File: rtl/qadd.sv
// Saturating signed adder; Q only names the binary point for callers.
module qadd
  import qadd_pkg::*;
#(
  parameter int N = QADD_N,
  parameter int Q = QADD_Q
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum,
  output logic         o_sat
);
  localparam logic [N-1:0] SMAX = N'(sat_max(N));
  localparam logic [N-1:0] SMIN = N'(sat_min(N));

  logic [N:0] w_s;

  assign w_s   = {i_a[N-1], i_a} + {i_b[N-1], i_b};
  // Top two bits of the sign-extended sum disagree only when equal-sign operands overflow.
  assign o_sat = w_s[N] ^ w_s[N-1];
  assign o_sum = o_sat ? (w_s[N] ? SMIN : SMAX) : w_s[N-1:0];
endmodule

// File: rtl/qadd_rr_share_rr_arb.sv
// Round-robin candidate search starting at ptr; grant gated by en.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt[gnt_idx] = en & any;
  end
endmodule

// File: rtl/qadd_rr_share.sv
// One qadd shared by NREQ requesters: round-robin grant, operand stage, result stage.
module qadd_rr_share
  import qadd_pkg::*;
#(
  parameter int N    = QADD_N,
  parameter int Q    = QADD_Q,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  qadd_rr_share_if.slave bus
);
  logic            w_adv1, w_adv2, w_en, w_any, w_acc, w_sat;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic [N-1:0]    w_sum;

  logic            r_v1;
  logic [N-1:0]    r_a1, r_b1;
  logic [IDW-1:0]  r_id1, r_ptr;
  logic            r_rsp_valid, r_rsp_sat;
  logic [N-1:0]    r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;

  assign w_adv2 = ~r_rsp_valid | bus.rsp_ready;
  assign w_adv1 = ~r_v1 | w_adv2;
  // Grants are suppressed while reset is held so nothing is handshaken into a clearing pipe.
  assign w_en   = w_adv1 & ~rst;
  assign w_acc  = w_any & w_en;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  qadd #(.N(N), .Q(Q)) u_qadd (
    .i_a   (r_a1),
    .i_b   (r_b1),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_v1  <= 1'b0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_id1 <= '0;
    end else begin
      if (w_adv1) r_v1 <= w_acc;
      if (w_acc) begin
        r_a1  <= bus.req_a[w_gnt_idx];
        r_b1  <= bus.req_b[w_gnt_idx];
        r_id1 <= w_gnt_idx;
        r_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_sat   <= 1'b0;
    end else if (w_adv2) begin
      r_rsp_valid <= r_v1;
      if (r_v1) begin
        r_rsp_data <= w_sum;
        r_rsp_id   <= r_id1;
        r_rsp_sat  <= w_sat;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sat   = r_rsp_sat;
endmodule
